// File: rtl/mips_seq_alu.sv
// mips_seq_alu -- multi-cycle execute-stage ALU.
//
// Purpose:
//   Single-cycle integer ops (AND/OR/ADD/XOR/NOR/SUB/SLT/SLTU/MFHI/MFLO/NOOP)
//   return a registered result one cycle after acceptance, back-to-back.
//   MULT/MULTU run WIDTH shift-add iterations; DIV/DIVU run WIDTH restoring
//   iterations plus a sign-fix cycle. Both write the internal HI/LO pair.
//   The block only takes a new request in IDLE, which stalls the pipeline
//   while a long operation runs.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready request handshake; in_ready is high only in IDLE
//   op, a, b, cin       operation code, operands, carry-in (ADD only)
//   res_valid           one-cycle pulse: res_data and flags are new
//   res_data            result (LO for MULT/DIV ops)
//   zero, ovf, cout     result flags, held until the next result
//   dz                  divide by zero (DIV/DIVU only)
//   err                 invalid op code (5)
module mips_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             zero,
  output logic             ovf,
  output logic             cout,
  output logic             dz,
  output logic             err
);

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_NOR   = 4'h4;
  localparam logic [3:0] OP_BAD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_SLTU  = 4'h8;
  localparam logic [3:0] OP_MULT  = 4'h9;
  localparam logic [3:0] OP_MULTU = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_MFHI  = 4'hD;
  localparam logic [3:0] OP_MFLO  = 4'hE;
  localparam logic [3:0] OP_NOOP  = 4'hF;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Magnitude of x when treated as signed (sgn=1); pass-through otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Control state (reset)
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                res_valid_q, res_valid_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                cout_q, cout_d;
  logic                dz_q, dz_d;
  logic                err_q, err_d;

  // Datapath state (no reset; always loaded before use)
  logic [3:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                cin_q, cin_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [2*WIDTH:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;

  // Combinational helpers
  logic                accept;
  logic                signed_op;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]      add_w, sub_w;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_ovf, alu_cout, alu_err;
  logic [WIDTH:0]      mul_upper;
  logic [2*WIDTH:0]    mul_next;
  logic [2*WIDTH-1:0]  mul_prod;
  logic [WIDTH:0]      div_shift, div_trial;
  logic                div_ge;
  logic [WIDTH-1:0]    rem_next, quo_next;
  logic [WIDTH-1:0]    fix_hi, fix_lo;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_s       = a_q;
  assign b_s       = b_q;

  // Single-cycle ops, evaluated on the operands captured at acceptance
  always_comb begin
    add_w    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sub_w    = {1'b0, a_q} - {1'b0, b_q};
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_ADD: begin
        alu_res  = add_w[WIDTH-1:0];
        alu_cout = add_w[WIDTH];
        alu_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = sub_w[WIDTH-1:0];
        alu_cout = sub_w[WIDTH];
        alu_ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_NOOP: alu_res = res_data_q;
      OP_BAD:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shift the whole
  // accumulator right. The extra top bit holds the carry of the add.
  always_comb begin
    mul_upper = acc_q[0] ? (acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q}) : acc_q[2*WIDTH:WIDTH];
    mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};
    mul_prod  = cond_neg2(mul_next[2*WIDTH-1:0], neg_res_q);
  end

  // Restoring-division step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only when it does not go negative.
  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor_q};
    div_ge    = ~div_trial[WIDTH];
    rem_next  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], div_ge};
    // For divide by zero, quo_q still holds the raw dividend.
    fix_lo    = div0_q ? '1 : cond_neg(quo_q, neg_res_q);
    fix_hi    = div0_q ? quo_q : cond_neg(rem_q, neg_rem_q);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
    dz_d        = dz_q;
    err_d       = err_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div0_d      = div0_q;

    // A single-cycle op accepted last edge retires now. It can never
    // coincide with a MUL/FIX completion because those states block accepts.
    if (pend_q) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res;
      zero_d      = ~|alu_res;
      ovf_d       = alu_ovf;
      cout_d      = alu_cout;
      dz_d        = 1'b0;
      err_d       = alu_err;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          cin_d = cin;
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d   = S_MUL;
              cnt_d     = '0;
              mcand_d   = mag(a, signed_op);
              acc_d     = {{(WIDTH+1){1'b0}}, mag(b, signed_op)};
              neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                state_d = S_FIX;
                div0_d  = 1'b1;
                quo_d   = a;
              end else begin
                state_d   = S_DIV;
                cnt_d     = '0;
                div0_d    = 1'b0;
                rem_d     = '0;
                quo_d     = mag(a, signed_op);
                divisor_d = mag(b, signed_op);
                neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_d = signed_op && a[WIDTH-1];
              end
            end
            default: pend_d = 1'b1;
          endcase
        end
      end

      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = S_IDLE;
          hi_d        = mul_prod[2*WIDTH-1:WIDTH];
          lo_d        = mul_prod[WIDTH-1:0];
          res_valid_d = 1'b1;
          res_data_d  = mul_prod[WIDTH-1:0];
          zero_d      = ~|mul_prod[WIDTH-1:0];
          ovf_d       = 1'b0;
          cout_d      = 1'b0;
          dz_d        = 1'b0;
          err_d       = 1'b0;
        end
      end

      S_DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d     = S_IDLE;
        hi_d        = fix_hi;
        lo_d        = fix_lo;
        res_valid_d = 1'b1;
        res_data_d  = fix_lo;
        zero_d      = ~|fix_lo;
        ovf_d       = 1'b0;
        cout_d      = 1'b0;
        dz_d        = div0_q;
        err_d       = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    a_q       <= a_d;
    b_q       <= b_d;
    cin_q     <= cin_d;
    mcand_q   <= mcand_d;
    acc_q     <= acc_d;
    divisor_q <= divisor_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign cout      = cout_q;
  assign dz        = dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mips_seq_alu.sv
// Scoreboard bench for mips_seq_alu: a WIDTH=32 and a WIDTH=8 instance.
// Stimulus pushes the hand-computed response (data, flags, cycle) into a
// queue; per-instance monitors pop and compare on every res_valid.
module tb_mips_seq_alu;

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_NOR   = 4'h4;
  localparam logic [3:0] OP_BAD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_SLTU  = 4'h8;
  localparam logic [3:0] OP_MULT  = 4'h9;
  localparam logic [3:0] OP_MULTU = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_MFHI  = 4'hD;
  localparam logic [3:0] OP_MFLO  = 4'hE;
  localparam logic [3:0] OP_NOOP  = 4'hF;

  // flags packing: {zero, ovf, cout, dz, err}
  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin;
  logic [3:0]  op;
  logic [31:0] a, b, res_data;
  logic        res_valid, zero, ovf, cout, dz, err;

  logic        in_valid8, in_ready8, cin8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res_data8;
  logic        res_valid8, zero8, ovf8, cout8, dz8, err8;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t q32[$];
  exp_t q8[$];

  always @(posedge clk) cyc <= cyc + 1;

  mips_seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .res_valid(res_valid),
    .res_data(res_data), .zero(zero), .ovf(ovf), .cout(cout), .dz(dz), .err(err)
  );

  mips_seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .cin(cin8), .res_valid(res_valid8),
    .res_data(res_data8), .zero(zero8), .ovf(ovf8), .cout(cout8), .dz(dz8), .err(err8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result_w32: got %h expected no result", res_data);
      end else begin
        e = q32.pop_front();
        chk({e.name, "_data"}, res_data, e.data);
        chk({e.name, "_flags"}, {27'b0, zero, ovf, cout, dz, err}, {27'b0, e.flags});
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && res_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result_w8: got %h expected no result", res_data8);
      end else begin
        e = q8.pop_front();
        chk({e.name, "_data"}, {24'b0, res_data8}, e.data);
        chk({e.name, "_flags"}, {27'b0, zero8, ovf8, cout8, dz8, err8}, {27'b0, e.flags});
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present a request (held while in_ready is low), push the expected
  // response once acceptance is certain at the next rising edge.
  task automatic issue32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic [31:0] d, input logic [4:0] f,
                         input int lat, input string nm);
    int w;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; cin = c;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 100 cycles", nm);
      in_valid = 1'b0;
      return;
    end
    q32.push_back('{data: d, flags: f, cyc: cyc + 1 + lat, name: nm});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] d, input logic [4:0] f,
                        input int lat, input string nm);
    int w;
    @(negedge clk);
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y; cin8 = 1'b0;
    w = 0;
    while (!in_ready8 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready8) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 100 cycles", nm);
      in_valid8 = 1'b0;
      return;
    end
    q8.push_back('{data: {24'b0, d}, flags: f, cyc: cyc + 1 + lat, name: nm});
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    in_valid = 1'b0; op = OP_NOOP; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; op8 = OP_NOOP; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    chk("reset_flags", {27'b0, zero, ovf, cout, dz, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops
    issue32(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 5'b10100, 1, "add_wrap");
    issue32(OP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 5'b01000, 1, "sub_ovf");
    issue32(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 5'b00000, 1, "slt_neg");
    issue32(OP_NOOP, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0001, 5'b00000, 1, "noop");
    issue32(OP_ADD,  32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0000_000C, 5'b00000, 1, "add_cin");
    issue32(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 5'b01000, 1, "add_ovf");
    issue32(OP_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 5'b00100, 1, "sub_borrow");
    issue32(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 5'b00000, 1, "and");
    issue32(OP_OR,   32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 5'b00000, 1, "or");
    issue32(OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555, 5'b00000, 1, "xor");
    issue32(OP_NOR,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 5'b00000, 1, "nor");
    issue32(OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 5'b00000, 1, "sltu");
    issue32(OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 5'b10000, 1, "slt_pos");
    issue32(OP_BAD,  32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0000_0000, 5'b10001, 1, "bad_op");

    // Multiply; the MFHI behind it is held on in_valid until in_ready rises
    issue32(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'hFFFF_FFEB, 5'b00000, 32, "mult");
    issue32(OP_MFHI,  32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 5'b00000, 1, "mfhi_mult");
    issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 5'b00000, 32, "multu");
    issue32(OP_MFHI,  32'h0, 32'h0, 1'b0, 32'hFFFF_FFFE, 5'b00000, 1, "mfhi_multu");
    issue32(OP_ADD,   32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 5'b00000, 1, "add_after_mul");

    // Divide
    issue32(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD, 5'b00000, 33, "div_neg");
    issue32(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 5'b00000, 1, "mfhi_div_neg");
    issue32(OP_DIVU, 32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0000_0003, 5'b00000, 33, "divu");
    issue32(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h0000_0001, 5'b00000, 1, "mfhi_divu");
    issue32(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 5'b00000, 33, "div_min");
    issue32(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 5'b10000, 1, "mfhi_div_min");
    issue32(OP_DIVU, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 5'b00010, 1, "divu_zero");
    issue32(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h0000_0005, 5'b00000, 1, "mfhi_dz");
    issue32(OP_MFLO, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 5'b00000, 1, "mflo_dz");

    // Reset during the tenth divide iteration
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res_data", res_data, 32'd0);
    chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    issue32(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 5'b10000, 1, "mfhi_after_rst");
    issue32(OP_MFLO, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 5'b10000, 1, "mflo_after_rst");

    // Narrow instance
    issue8(OP_MULTU, 8'hFF, 8'hFF, 8'h01, 5'b00000, 8, "w8_multu");
    issue8(OP_MFHI,  8'h00, 8'h00, 8'hFE, 5'b00000, 1, "w8_mfhi");
    issue8(OP_SLTU,  8'h80, 8'h01, 8'h00, 5'b10000, 1, "w8_sltu");
    issue8(OP_SUB,   8'h80, 8'h01, 8'h7F, 5'b01000, 1, "w8_sub_ovf");

    w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d results still outstanding expected 0", q32.size() + q8.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
